// File: rtl/pipemem_pkg.sv
// pipe_pkg: shared datapath widths and the MEM-stage state encoding
package pipe_pkg;
  localparam int WORD_W = 32;
  localparam int RN_W = 5;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/pipemem_if.sv
// pipemem_if: data-memory port; master (MEM stage) drives req/we/addr/wdata and takes ack/rdata back
interface pipemem_if;
  import pipe_pkg::*;
  logic req, we, ack;
  logic [WORD_W-3:0] addr;
  logic [WORD_W-1:0] wdata, rdata;
  modport master(output req, we, addr, wdata, input ack, rdata);
  modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/pipemem_timer.sv
// pipemem_timer: wait counter (clock/reset/clr/load/en in, expired out); load starts at 1, expired once it reaches TIMEOUT
module pipemem_timer #(parameter int TIMEOUT = 15) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clock)
    if (reset || clr) cnt <= '0;
    else if (load) cnt <= 8'd1;
    else if (en) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(TIMEOUT);
endmodule

// File: rtl/pipemem.sv
// pipemem: MEM stage; EX/MEM fields in (em*), MEM/WB fields out (m*), mstall upstream, dmem req/ack master port, sticky merr
module pipemem import pipe_pkg::*; #(parameter int TIMEOUT = 15) (
  input  logic              clock,
  input  logic              reset,
  input  logic              emwreg,
  input  logic              emm2reg,
  input  logic              emwmem,
  input  logic [WORD_W-1:0] emalu,
  input  logic [WORD_W-1:0] emb,
  input  logic [RN_W-1:0]   emrn,
  output logic              mwreg,
  output logic              mm2reg,
  output logic [WORD_W-1:0] mmo,
  output logic [WORD_W-1:0] malu,
  output logic [RN_W-1:0]   mrn,
  output logic              mstall,
  output logic              merr,
  pipemem_if.master         dmem
);
  mem_state_t state, nxt;
  logic memop, misal, go, fin, expired, abort, req;
  logic [WORD_W-1:0] mmo_r;
  assign memop = emm2reg | emwmem;
  assign misal = memop & (emalu[1:0] != 2'b00);
  assign go = state == IDLE && memop && !misal;
  assign fin = state == WAIT && (dmem.ack || expired);
  pipemem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock,
    .reset,
    .clr(state == DONE),
    .load(go),
    .en(state == WAIT),
    .expired
  );
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  always_comb nxt = go ? WAIT : fin ? DONE : state == WAIT ? WAIT : IDLE;
  always_comb begin
    mstall = go || state == WAIT;
    mwreg = mstall ? 1'b0 : state == DONE ? emwreg & ~abort : emwreg & ~misal;
    mm2reg = mstall ? 1'b0 : emm2reg;
    mmo = state == DONE && !abort ? mmo_r : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      req <= 1'b0;
      abort <= 1'b0;
      merr <= 1'b0;
      mmo_r <= '0;
    end else begin
      req <= go || (state == WAIT && !fin);
      abort <= fin && !dmem.ack;
      merr <= merr || (state == IDLE && misal) || (fin && !dmem.ack);
      if (state == WAIT && dmem.ack) mmo_r <= emm2reg ? dmem.rdata : '0;
    end
  assign dmem.req = req;
  assign dmem.we = emwmem;
  assign dmem.addr = emalu[WORD_W-1:2];
  assign dmem.wdata = emb;
  assign malu = emalu;
  assign mrn = emrn;
endmodule

// File: doc/pipemem.md
# pipemem

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register and takes the EX/MEM fields (control, ALU result, store data, destination register). It performs word loads and stores through a req/ack data-memory port and presents `mwreg/mm2reg/mmo/malu/mrn` to MEM/WB. While a memory access is outstanding it stalls upstream stages and sends a bubble downstream.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles waiting for `dmem_ack` before the access is aborted (range 1..255).

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `emwreg` in 1: EX/MEM register-write enable.
- `emm2reg` in 1: EX/MEM load select; 1 means load.
- `emwmem` in 1: EX/MEM store enable.
- `emalu` in 32: EX/MEM ALU result; also the memory byte address.
- `emb` in 32: EX/MEM store data.
- `emrn` in 5: EX/MEM destination register.
- `mwreg` out 1: register-write enable to MEM/WB.
- `mm2reg` out 1: load select to MEM/WB.
- `mmo` out 32: load data to MEM/WB.
- `malu` out 32: ALU result to MEM/WB.
- `mrn` out 5: destination register to MEM/WB.
- `mstall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `dmem_req` out 1: memory request. Registered.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 30: word address, equal to `emalu[31:2]`.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: memory completion. Sampled only in WAIT.
- `dmem_rdata` in 32: read data. Valid when `dmem_ack` is high.
- `merr` out 1: sticky error flag (timeout or misalignment). Cleared only by reset.

## Operation
- `memop = emm2reg | emwmem`. `misal = memop & (emalu[1:0] != 0)`.
- FSM states:
  - IDLE:
    - `memop & ~misal` → WAIT, and the WAIT-cycle `dmem_req` is registered to 1.
    - Non-memory ops pass through combinationally: `mmo = 0`, `mwreg = emwreg`.
    - `misal`: no request is issued; `mwreg` forced 0; `merr` set next edge; stays IDLE. The instruction is dropped.
  - WAIT:
    - `dmem_req = 1`. `dmem_we/addr/wdata` are driven from the EX/MEM inputs, which are held stable by `mstall`.
    - Wait counter increments each cycle.
    - `dmem_ack` → capture `dmem_rdata` (loads) into `mmo_r`, clear `dmem_req`, go to DONE.
    - Counter reaches `TIMEOUT` without ack → clear `dmem_req`, set `merr`, set `abort`, go to DONE.
  - DONE:
    - `mstall = 0`.
    - `mwreg = emwreg & ~abort`.
    - `mmo = abort ? 0 : mmo_r`.
    - Next state IDLE; `abort` cleared.
- `mstall = (IDLE & memop & ~misal) | WAIT`.
- While `mstall` is high, `mwreg = 0` and `mm2reg = 0` (bubble). `malu/mrn` still follow the inputs.
- Stores: `mmo = 0`; `mwreg` is passed through as-is (normally 0).
- Reset, including mid-access:
  - state IDLE; `dmem_req` 0; `mmo_r` 0; counter 0; `abort` 0; `merr` 0.
  - A pending memory transaction is abandoned. An ack arriving after reset is ignored, since it is outside WAIT.

## Timing
- Non-memory op: zero added latency; appears at MEM/WB next edge.
- Memory op with ack in the first WAIT cycle: 3 cycles in this stage (IDLE detect, WAIT, DONE); `mstall` high for 2 cycles.
- Ack after k WAIT cycles: `mstall` high for k+1 cycles.
- Timeout: `mstall` high for TIMEOUT+1 cycles; `merr` rises at the edge leaving WAIT.
- `dmem_req` rises at the edge after the op is detected. It falls at the edge after ack or timeout. There is never a request in IDLE or DONE.
- Back-to-back memory ops: DONE → IDLE sees the next op and goes straight back to WAIT. There is no idle gap other than the DONE cycle.

## Structure
- Shared package `pipe_pkg`:
  - `WORD_W = 32`, `RN_W = 5`.
  - State enum `mem_state_t` with values {IDLE, WAIT, DONE}.
- Sub-module `pipemem_timer`: loadable wait counter with clear, enable, and `expired` output at `TIMEOUT`.
- Everything else is inline: FSM, capture register, and the output mux.

## Test plan
- ALU op (`emwreg=1`, `emalu=0x1234`, `emrn=5`, no memop) → same cycle `mwreg=1`, `malu=0x1234`, `mrn=5`, `mmo=0`, `mstall=0`.
- Load at `emalu=0x40`, memory acks in first WAIT cycle with `0xDEADBEEF`:
  - `dmem_addr=0x10`, `dmem_we=0`;
  - `mstall` high for 2 cycles;
  - DONE cycle shows `mm2reg=1`, `mwreg=1`, `mmo=0xDEADBEEF`.
- Store at `0x80` with data `0xA5A5A5A5`, ack after 3 WAIT cycles → `dmem_we=1`, `dmem_wdata=0xA5A5A5A5`, `mstall` high for 4 cycles, `mwreg=0` throughout.
- Load with no ack, `TIMEOUT=15`:
  - `dmem_req` high for exactly 15 cycles;
  - `merr=1` afterwards;
  - DONE cycle has `mwreg=0`, `mmo=0`.
- Misaligned load at `0x42` → no `dmem_req`, `mstall=0`, `mwreg=0`, `merr=1` next cycle.
- Reset asserted during WAIT, ack presented the cycle after → state IDLE, `dmem_req=0`, `merr=0`, ack ignored, `mmo=0`.
